// File: rtl/wormhole_out_port.sv
// wormhole_out_port
// Output-port controller placed after the round-robin arbiter. In IDLE it
// sends head-flit requests to the arbiter and accepts the one-hot grant. The
// winning input then stays locked for the rest of its wormhole packet. Its
// flits are forwarded through a registered output stage, gated by a credit
// counter that tracks free slots downstream.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/head/tail/flit   per-input queue-head flit and framing
//   in_ready        combinational pop strobe to each input
//   arb_request     combinational request vector to the arbiter
//   arb_grant, arb_any_grant  arbiter grant (same cycle)
//   out_valid/flit/head/tail  registered output flit
//   credit_in       one pulse per freed downstream slot
//   credit_cnt      current credit count
//   err             sticky protocol error
//
// state  | meaning
// IDLE   | no packet in flight; head flits compete through the arbiter
// LOCKED | owner holds the port until its tail flit is transferred

module wormhole_out_port #(
    parameter int ARBITER_WIDTH = 4,
    parameter int FLIT_WIDTH    = 32,
    parameter int CREDIT_DEPTH  = 4,
    localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ARBITER_WIDTH-1:0]            in_valid,
    input  logic [ARBITER_WIDTH-1:0]            in_head,
    input  logic [ARBITER_WIDTH-1:0]            in_tail,
    input  logic [ARBITER_WIDTH*FLIT_WIDTH-1:0] in_flit,
    output logic [ARBITER_WIDTH-1:0]            in_ready,
    output logic [ARBITER_WIDTH-1:0]            arb_request,
    input  logic [ARBITER_WIDTH-1:0]            arb_grant,
    input  logic                                arb_any_grant,
    output logic                                out_valid,
    output logic [FLIT_WIDTH-1:0]               out_flit,
    output logic                                out_head,
    output logic                                out_tail,
    input  logic                                credit_in,
    output logic [CW-1:0]                       credit_cnt,
    output logic                                err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

    state_t                   state_q, state_d;
    logic [ARBITER_WIDTH-1:0] owner_q, owner_d;
    logic [CW-1:0]            credit_q, credit_d;
    logic                     out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0]    out_flit_q, out_flit_d;
    logic                     out_head_q, out_head_d;
    logic                     out_tail_q, out_tail_d;
    logic                     err_q, err_d;

    logic                     has_credit;
    logic                     grant_ok;
    logic                     xfer;
    logic [ARBITER_WIDTH-1:0] sel;
    logic [FLIT_WIDTH-1:0]    sel_flit;
    logic                     sel_head;
    logic                     sel_tail;

    always_comb begin
        has_credit  = (credit_q != '0);
        arb_request = '0;
        sel         = '0;
        xfer        = 1'b0;
        sel_flit    = '0;
        sel_head    = 1'b0;
        sel_tail    = 1'b0;
        state_d     = state_q;
        owner_d     = owner_q;
        credit_d    = credit_q;
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        out_head_d  = out_head_q;
        out_tail_d  = out_tail_q;
        err_d       = err_q;

        // Requests are suppressed while LOCKED so the arbiter pointer only
        // moves at packet boundaries.
        if (state_q == IDLE && has_credit) begin
            arb_request = in_valid & in_head;
        end

        // A grant outside the request vector covers the LOCKED case too,
        // since nothing is requested there.
        grant_ok = arb_any_grant && ($countones(arb_grant) == 1) &&
                   ((arb_grant & ~arb_request) == '0);
        if (arb_any_grant && !grant_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    sel  = arb_grant;
                    xfer = 1'b1;
                end
            end
            LOCKED: begin
                if (((in_valid & owner_q) != '0) && has_credit) begin
                    sel  = owner_q;
                    xfer = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready = sel;

        // sel is one-hot or zero, so OR-ing the selected lanes is a mux.
        for (int i = 0; i < ARBITER_WIDTH; i++) begin
            if (sel[i]) begin
                sel_flit = sel_flit | in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_head = sel_head | in_head[i];
                sel_tail = sel_tail | in_tail[i];
            end
        end

        if (xfer) begin
            out_valid_d = 1'b1;
            out_flit_d  = sel_flit;
            out_head_d  = sel_head;
            out_tail_d  = sel_tail;
            if (state_q == IDLE) begin
                owner_d = sel;
                if (!sel_tail) begin
                    state_d = LOCKED;
                end
            end else begin
                // A head inside a packet is still forwarded, only flagged.
                if (sel_head) begin
                    err_d = 1'b1;
                end
                if (sel_tail) begin
                    state_d = IDLE;
                end
            end
        end

        if (xfer && !credit_in) begin
            credit_d = credit_q - CREDIT_ONE;
        end else if (!xfer && credit_in) begin
            if (credit_q == CREDIT_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CREDIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            credit_q    <= CREDIT_MAX;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_head_q  <= out_head_d;
            out_tail_q  <= out_tail_d;
            err_q       <= err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign out_head   = out_head_q;
    assign out_tail   = out_tail_q;
    assign credit_cnt = credit_q;
    assign err        = err_q;

endmodule

// File: tb/tb_wormhole_out_port.sv
// Testbench for wormhole_out_port. Each input holds a queue of whole packets.
// A round-robin arbiter model and a credit-returning downstream model drive
// the stimulus. A transaction-level model (owner index, credit integer,
// sticky error) predicts every cycle.
module tb_wormhole_out_port;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    typedef struct packed {
        logic         h;
        logic         t;
        logic [W-1:0] d;
    } flit_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid, in_head, in_tail, in_ready;
    logic [N*W-1:0]  in_flit;
    logic [N-1:0]    arb_request, arb_grant;
    logic            arb_any_grant;
    logic            out_valid, out_head, out_tail;
    logic [W-1:0]    out_flit;
    logic            credit_in;
    logic [CW-1:0]   credit_cnt;
    logic            err;

    always #5 clk = ~clk;

    wormhole_out_port #(.ARBITER_WIDTH(N), .FLIT_WIDTH(W), .CREDIT_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail), .in_flit(in_flit),
        .in_ready(in_ready), .arb_request(arb_request),
        .arb_grant(arb_grant), .arb_any_grant(arb_any_grant),
        .out_valid(out_valid), .out_flit(out_flit), .out_head(out_head), .out_tail(out_tail),
        .credit_in(credit_in), .credit_cnt(credit_cnt), .err(err)
    );

    flit_t pq [N][$];
    int    n_cmp = 0;
    int    n_bad = 0;

    int    m_owner;
    int    m_cred;
    bit    m_err;
    bit    m_ov;
    flit_t m_out;
    int    rr_ptr;
    int    ds_occ;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int port, input int len);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.h = (k == 0);
            f.t = (k == len - 1);
            f.d = $urandom;
            pq[port].push_back(f);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cred  = D;
        m_err   = 1'b0;
        m_ov    = 1'b0;
        m_out   = '0;
        rr_ptr  = 0;
        ds_occ  = 0;
        for (int i = 0; i < N; i++) pq[i].delete();
    endtask

    task automatic idle_inputs();
        in_valid      = '0;
        in_head       = '0;
        in_tail       = '0;
        in_flit       = '0;
        arb_grant     = '0;
        arb_any_grant = 1'b0;
        credit_in     = 1'b0;
    endtask

    function automatic bit busy();
        bit b = (m_owner >= 0) || (ds_occ > 0);
        for (int i = 0; i < N; i++) if (pq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input bit bad, input bit fcin, input int avail, input int cinp);
        logic [N-1:0] req, gnt, pop;
        int           xi;
        flit_t        f;
        in_valid = '0;
        in_head  = '0;
        in_tail  = '0;
        for (int i = 0; i < N; i++) begin
            in_flit[i*W +: W] = $urandom;
            if (pq[i].size() > 0 && $urandom_range(99) < avail) begin
                in_valid[i]       = 1'b1;
                in_head[i]        = pq[i][0].h;
                in_tail[i]        = pq[i][0].t;
                in_flit[i*W +: W] = pq[i][0].d;
            end else begin
                in_head[i] = 1'($urandom_range(1));
                in_tail[i] = 1'($urandom_range(1));
            end
        end
        req = '0;
        if (m_owner < 0 && m_cred > 0) req = in_valid & in_head;
        gnt = '0;
        if (bad) begin
            gnt = 4'b0011;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx = (rr_ptr + k) % N;
                if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
            end
        end
        arb_grant     = gnt;
        arb_any_grant = (gnt != '0);
        credit_in     = fcin || (ds_occ > 0 && $urandom_range(99) < cinp);

        xi = -1;
        if (arb_any_grant && !($countones(gnt) == 1 && (gnt & ~req) == '0)) m_err = 1'b1;
        if (m_owner < 0) begin
            if (arb_any_grant && $countones(gnt) == 1 && (gnt & ~req) == '0) xi = $clog2(gnt);
        end else if (in_valid[m_owner] && m_cred > 0) begin
            xi = m_owner;
        end
        pop = '0;
        if (xi >= 0) pop[xi] = 1'b1;

        #1;
        chk("arb_request", 64'(arb_request), 64'(req));
        chk("in_ready", 64'(in_ready), 64'(pop));

        if (xi >= 0) begin
            f     = pq[xi].pop_front();
            m_ov  = 1'b1;
            m_out = f;
            if (m_owner < 0) begin
                rr_ptr = (xi + 1) % N;
                if (!f.t) m_owner = xi;
            end else begin
                if (f.h) m_err = 1'b1;
                if (f.t) m_owner = -1;
            end
        end else begin
            m_ov = 1'b0;
        end
        if (xi >= 0 && !credit_in) begin
            m_cred--;
            ds_occ++;
        end else if (xi < 0 && credit_in) begin
            if (m_cred == D) m_err = 1'b1;
            else m_cred++;
            if (ds_occ > 0) ds_occ--;
        end

        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_flit", 64'(out_flit), 64'(m_out.d));
        chk("out_head", 64'(out_head), 64'(m_out.h));
        chk("out_tail", 64'(out_tail), 64'(m_out.t));
        chk("credit_cnt", 64'(credit_cnt), 64'(m_cred));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_credit", 64'(credit_cnt), 64'(D));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        flit_t f;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_out_head", 64'(out_head), 64'(0));
        chk("rst_out_tail", 64'(out_tail), 64'(0));
        chk("rst_credit", 64'(credit_cnt), 64'(D));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_arb_request", 64'(arb_request), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single 3-flit packet on input 2, no credit return.
        gen_pkt(2, 3);
        repeat (4) step(1'b0, 1'b0, 100, 0);
        chk("three_flit_credit", 64'(credit_cnt), 64'(1));
        repeat (5) step(1'b0, 1'b0, 100, 100);

        // Simultaneous 2-flit packets on inputs 0 and 1.
        gen_pkt(0, 2);
        gen_pkt(1, 2);
        repeat (6) step(1'b0, 1'b0, 100, 0);
        repeat (6) step(1'b0, 1'b0, 100, 100);

        // Randomized traffic with delayed credit return.
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 2) gen_pkt(i, $urandom_range(1, 4));
            end
            step(1'b0, 1'b0, 75, 35);
        end
        for (int c = 0; c < 400 && busy(); c++) step(1'b0, 1'b0, 100, 60);
        chk("drain_credit", 64'(credit_cnt), 64'(D));

        // Credit pulse at the full count.
        step(1'b0, 1'b1, 100, 0);
        chk("cfull_err", 64'(err), 64'(1));
        chk("cfull_credit", 64'(credit_cnt), 64'(D));
        step(1'b0, 1'b0, 100, 0);

        // Reset after the second flit of a 4-flit packet.
        do_reset();
        gen_pkt(1, 4);
        repeat (2) step(1'b0, 1'b0, 100, 0);
        do_reset();
        gen_pkt(3, 3);
        repeat (5) step(1'b0, 1'b0, 100, 0);
        repeat (4) step(1'b0, 1'b0, 100, 100);

        // Non-one-hot grant: nothing popped, err sticks.
        gen_pkt(2, 2);
        step(1'b1, 1'b0, 100, 0);
        chk("badgnt_err", 64'(err), 64'(1));
        repeat (5) step(1'b0, 1'b0, 100, 100);
        chk("badgnt_err_sticky", 64'(err), 64'(1));

        // Head flag on the owner's flit while locked.
        do_reset();
        f.h = 1'b1; f.t = 1'b0; f.d = $urandom; pq[0].push_back(f);
        f.h = 1'b1; f.t = 1'b0; f.d = $urandom; pq[0].push_back(f);
        f.h = 1'b0; f.t = 1'b1; f.d = $urandom; pq[0].push_back(f);
        repeat (5) step(1'b0, 1'b0, 100, 100);
        chk("locked_head_err", 64'(err), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wormhole_out_port.md
# wormhole_out_port

Output-port controller for the router: sits directly downstream of the thermometer round-robin arbiter. It presents head-flit requests from the input ports to the arbiter and consumes the one-hot grant. It locks the winning input for the whole wormhole packet and forwards that input's flits through a registered output stage. Forwarding is gated by a credit counter that tracks free slots in the next router's input buffer.

## Interface
- ARBITER_WIDTH, 4, number of input ports; matches the arbiter's width.
- FLIT_WIDTH, 32, flit payload bits.
- CREDIT_DEPTH, 4, downstream buffer depth in flits; must be ≥1.
- Derived: CW = $clog2(CREDIT_DEPTH+1), credit counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  ARBITER_WIDTH  input i has a flit at its queue head.
- in_head  in  ARBITER_WIDTH  the head flit of input i is a packet head.
- in_tail  in  ARBITER_WIDTH  the head flit of input i is a packet tail; head+tail together mean a single-flit packet.
- in_flit  in  ARBITER_WIDTH*FLIT_WIDTH  payloads; input i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_ready  out  ARBITER_WIDTH  pop strobe to input i; combinational.
- arb_request  out  ARBITER_WIDTH  request vector to the arbiter; combinational.
- arb_grant  in  ARBITER_WIDTH  one-hot grant from the arbiter, combinational in the same cycle.
- arb_any_grant  in  1  arbiter any_grant.
- out_valid  out  1  registered; a flit is on out_* this cycle.
- out_flit  out  FLIT_WIDTH  registered payload.
- out_head, out_tail  out  1 each  registered framing bits.
- credit_in  in  1  downstream freed one slot; one pulse per slot.
- credit_cnt  out  CW  current credit count.
- err  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE and LOCKED. Registers: owner (one-hot, ARBITER_WIDTH bits), credit_cnt, output register, err.
- has_credit = (credit_cnt != 0).
- In IDLE:
  - arb_request = in_valid & in_head, gated by has_credit.
  - A grant is valid when arb_any_grant=1, arb_grant is one-hot, and arb_grant ⊆ arb_request.
  - On a valid grant: in_ready = arb_grant, the granted flit is loaded into the output register, and owner <= arb_grant.
  - If that flit's tail bit is set, stay IDLE. Otherwise go to LOCKED.
- In LOCKED:
  - arb_request = 0, so the arbiter's priority pointer does not advance mid-packet.
  - A transfer happens when in_valid[owner] and has_credit: in_ready[owner]=1 and the flit is registered.
  - On a tail transfer, go to IDLE.
  - Other inputs never see in_ready.
- Non-head flit at a non-owner input in IDLE: not requested and not popped.
- Credits:
  - Each transfer decrements credit_cnt; each credit_in pulse increments it.
  - Transfer and credit_in in the same cycle leave credit_cnt unchanged.
  - credit_in while credit_cnt == CREDIT_DEPTH with no transfer: count saturates and err is set.
- Errors:
  - err is set by an invalid grant while arb_any_grant=1: not one-hot, or a grant to a non-requester.
  - err is set by in_head=1 on the owner's flit while LOCKED.
  - On an invalid grant: no transfer, state unchanged.
  - On a LOCKED head flit: the flit is still forwarded and err is set.
  - err is cleared only by reset.

## Timing
- Reset values: state=IDLE, owner=0, credit_cnt=CREDIT_DEPTH, out_valid=0, out_flit=0, out_head=0, out_tail=0, err=0.
- in_ready and arb_request are combinational from state, owner, credit_cnt and the inputs.
- Latency: a flit popped in cycle N appears on out_* with out_valid=1 in cycle N+1.
- out_valid lasts exactly one cycle per transfer. The output register holds its last value when there is no transfer; only out_valid drops.
- Throughput: one flit per cycle while credits last.
- A new packet can start in the cycle after a tail transfer. A single-flit packet every cycle is legal.
- Credit flow:
  - With credit_cnt=0 there are no transfers and no requests in IDLE.
  - A credit_in in cycle N permits a transfer in cycle N+1.
- Reset asserted mid-packet: outputs and state return to reset values immediately (asynchronous). The partial packet is abandoned. Upstream must flush.

## Test plan
- Single 3-flit packet on input 2, CREDIT_DEPTH=4, no credit_in:
  - out_valid for 3 consecutive cycles with head/body/tail framing; credit_cnt goes 4→1; state returns to IDLE.
- Heads on inputs 0 and 1 at once, 2-flit packets each:
  - one packet completes without interleaving; the other follows immediately after the tail.
  - arb_request=0 during the LOCKED cycle.
- CREDIT_DEPTH=2, 4-flit packet, credit_in pulses delayed:
  - transfers stall at credit_cnt=0; each credit_in allows exactly one more flit the following cycle.
- Transfer and credit_in in the same cycle at credit_cnt=3:
  - credit_cnt stays 3.
- Protocol errors:
  - forced arb_grant=4'b0011 → no pop, err=1 and it stays set.
  - a separate credit_in at the full count → credit_cnt stays at CREDIT_DEPTH, err=1.
- reset low during the second flit of a 4-flit packet:
  - out_valid=0 and credit_cnt=CREDIT_DEPTH immediately; after release, a new head on input 3 is granted normally.
